// File: rtl/ct_spsram_2048x32_ctrl_if.sv
// Request/response bus between a requester and the 2048x32 SRAM front-end.
// master drives requests and response ready; slave is the controller.
interface ct_spsram_2048x32_ctrl_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              req_vld;
    logic              req_rdy;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data
    );
endinterface

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Front-end for the 2048x32 single-port SRAM: request handshake, byte-mask expansion,
// credit-protected read response FIFO. Define CT_SPSRAM_CTRL_INIT_EN for the INIT_DATA fill sweep.
module ct_spsram_2048x32_ctrl #(
    parameter int unsigned RSP_DEPTH = 4,
    parameter logic [31:0] INIT_DATA = 32'h0,
    localparam int unsigned ADDR_W   = 11,
    localparam int unsigned DATA_W   = 32
) (
    input  logic                CLK,
    input  logic                RST,
    ct_spsram_2048x32_ctrl_if.slave bus,
    output logic                init_done,
    output logic [ADDR_W-1:0]   sram_a,
    output logic                sram_cen,
    output logic                sram_gwen,
    output logic [DATA_W-1:0]   sram_wen,
    output logic [DATA_W-1:0]   sram_d,
    input  logic [DATA_W-1:0]   sram_q
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    logic              run;
    logic              rd_acc;
    logic              inflight;
    logic              push;
    logic              pop;
    logic              fifo_nempty;
    logic              credit_ok;
    logic [CRD_W-1:0]  credit_used;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

`ifdef CT_SPSRAM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_cnt;

    // State register and fill-sweep address counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
        end
    end
`else
    // Fill word only matters when the sweep is built in
    logic unused_init_data;
    assign unused_init_data = ^INIT_DATA;
`endif

    // Reads need a free FIFO slot counting the one already in the SRAM pipeline
    assign credit_used = CRD_W'(fifo_cnt) + CRD_W'(inflight);
    assign credit_ok   = credit_used < CRD_W'(RSP_DEPTH);

    // Next state, handshake and SRAM pin drive
    always_comb begin
        init_done   = 1'b0;
        bus.req_rdy = 1'b0;
        rd_acc      = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        state_d = state_q;
        run     = 1'b0;
        if (!RST) begin
            unique case (state_q)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt;
                    sram_d    = INIT_DATA;
                    if (init_cnt == ADDR_W'(2047)) state_d = ST_RUN;
                end
                ST_RUN:  run = 1'b1;
                default: ;
            endcase
        end
`else
        run = !RST;
`endif
        if (run) begin
            init_done   = 1'b1;
            bus.req_rdy = bus.req_wr | credit_ok;
            if (bus.req_vld && (bus.req_wr || credit_ok)) begin
                if (!bus.req_wr) begin
                    rd_acc   = 1'b1;
                    sram_cen = 1'b0;
                    sram_a   = bus.req_addr;
                end else if (bus.req_be != '0) begin
                    // An all-zero byte mask is accepted without touching the array
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_a    = bus.req_addr;
                    sram_d    = bus.req_wdata;
                    for (int i = 0; i < BE_W; i++) begin
                        sram_wen[8*i +: 8] = {8{~bus.req_be[i]}};
                    end
                end
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push        = inflight;
    assign fifo_nempty = (fifo_cnt != '0);
    assign pop         = fifo_nempty & bus.rsp_rdy;

    // Read pipeline flag and FIFO bookkeeping; reset drops any sram_q still in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            inflight <= rd_acc;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    // Response storage is not reset; the output is gated while empty
    always_ff @(posedge CLK) begin
        if (push) rsp_mem[wr_ptr] <= sram_q;
    end

    assign bus.rsp_vld  = fifo_nempty;
    assign bus.rsp_data = fifo_nempty ? rsp_mem[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop && fifo_cnt == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Directed bench for ct_spsram_2048x32_ctrl with a behavioural SRAM and a response scoreboard.
// Sweep checks are active when CT_SPSRAM_CTRL_INIT_EN is defined.
module tb_ct_spsram_2048x32_ctrl;
    localparam int unsigned RSP_DEPTH = 4;
    localparam logic [31:0] INIT_DATA = 32'hA5A5_A5A5;

    logic        CLK;
    logic        RST;
    logic        init_done;
    logic [10:0] sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [31:0] sram_wen;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    ct_spsram_2048x32_ctrl_if bus();

    ct_spsram_2048x32_ctrl #(.RSP_DEPTH(RSP_DEPTH), .INIT_DATA(INIT_DATA)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    logic [31:0] exp_q [$];
    int          rsp_cyc_q [$];
    logic [31:0] ref_mem  [2048];
    logic [31:0] sram_arr [2048];
    int          acc_cyc;
    logic        acc_cen, acc_gwen;
    logic [10:0] acc_a;
    logic [31:0] acc_wen, acc_d;
    int          w, wsum, n0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Behavioural 2048x32 SRAM: active-low enables, per-bit write mask, 1-cycle read
    always @(posedge CLK) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0) sram_arr[sram_a] <= (sram_arr[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else                    sram_q <= sram_arr[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response handshake is matched against the oldest accepted read
    always @(negedge CLK) begin
        if (bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
            rsp_cyc_q.push_back(cyc_cnt);
            if (exp_q.size() != 0) chk("rsp_data", bus.rsp_data, exp_q.pop_front());
            else                   chk("rsp_unexpected", 32'(bus.rsp_vld), 32'd0);
        end
    end

    task automatic issue(input logic wr, input logic [10:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int waits);
        waits         = 0;
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        @(negedge CLK);
        while (bus.req_rdy !== 1'b1 && waits < 64) begin
            @(negedge CLK);
            waits++;
        end
        chk("req_accept", 32'(bus.req_rdy), 32'd1);
        acc_cyc  = cyc_cnt;
        acc_cen  = sram_cen;
        acc_gwen = sram_gwen;
        acc_a    = sram_a;
        acc_wen  = sram_wen;
        acc_d    = sram_d;
        if (wr) begin
            for (int i = 0; i < 4; i++) if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
        @(posedge CLK); #1;
        bus.req_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        bus.rsp_rdy = 1'b1;
        while ((exp_q.size() != 0 || bus.rsp_vld !== 1'b0) && t < 64) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

`ifdef CT_SPSRAM_CTRL_INIT_EN
    // Called one step after the edge that starts sweep cycle 0
    task automatic check_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                chk({tag, "_first_rsp_vld"}, 32'(bus.rsp_vld), 32'd0);
                chk({tag, "_first_addr"}, 32'(sram_a), 32'd0);
            end
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 || sram_a !== 11'(i) ||
                sram_d !== INIT_DATA || init_done !== 1'b0 || bus.req_rdy !== 1'b0) bad++;
            @(posedge CLK); #1;
        end
        chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        @(negedge CLK);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_req_rdy"}, 32'(bus.req_rdy), 32'd1);
        @(posedge CLK); #1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = INIT_DATA;
    endtask
`endif

    initial begin
        RST = 1'b1;
        bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_be = '0; bus.rsp_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_rdy",   32'(bus.req_rdy),  32'd0);
        chk("rst_rsp_vld",   32'(bus.rsp_vld),  32'd0);
        chk("rst_rsp_data",  bus.rsp_data,      32'd0);
        chk("rst_init_done", 32'(init_done),    32'd0);
        chk("rst_cen",       32'(sram_cen),     32'd1);
        chk("rst_gwen",      32'(sram_gwen),    32'd1);
        chk("rst_wen",       sram_wen,          32'hFFFF_FFFF);
        chk("rst_a",         32'(sram_a),       32'd0);
        chk("rst_d",         sram_d,            32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.rsp_rdy = 1'b1;

`ifdef CT_SPSRAM_CTRL_INIT_EN
        check_sweep("sweep");
        issue(1'b0, 11'h7FF, 32'h0, 4'h0, w);
        drain();
`else
        @(negedge CLK);
        chk("run_init_done", 32'(init_done), 32'd1);
        chk("run_req_rdy",   32'(bus.req_rdy), 32'd1);
        @(posedge CLK); #1;
`endif

        // Byte-masked write, zero-enable write, read-back
        issue(1'b1, 11'h010, 32'h1111_1111, 4'hF, w);
        issue(1'b1, 11'h010, 32'hAABB_CCDD, 4'b0101, w);
        chk("bm_wen",  acc_wen,         32'hFF00_FF00);
        chk("bm_cen",  32'(acc_cen),    32'd0);
        chk("bm_gwen", 32'(acc_gwen),   32'd0);
        chk("bm_a",    32'(acc_a),      32'h010);
        chk("bm_d",    acc_d,           32'hAABB_CCDD);
        issue(1'b1, 11'h010, 32'h5555_5555, 4'h0, w);
        chk("be0_cen", 32'(acc_cen),    32'd1);
        issue(1'b0, 11'h010, 32'h0, 4'h0, w);
        chk("rd_cen",  32'(acc_cen),    32'd0);
        chk("rd_gwen", 32'(acc_gwen),   32'd1);
        chk("rd_wen",  acc_wen,         32'hFFFF_FFFF);
        chk("rd_a",    32'(acc_a),      32'h010);
        drain();

        // Streaming reads with rsp_rdy held high
        for (int i = 0; i < 4; i++) issue(1'b1, 11'(i), 32'hC0DE_0000 + 32'(i), 4'hF, w);
        rsp_cyc_q.delete();
        wsum = 0;
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 11'(i), 32'h0, 4'h0, w);
            if (i == 0) n0 = acc_cyc;
            wsum += w;
        end
        chk("stream_waits", 32'(wsum), 32'd0);
        drain();
        chk("stream_count", 32'(rsp_cyc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("stream_cycle", 32'((i < rsp_cyc_q.size()) ? rsp_cyc_q[i] - n0 : -1), 32'(i + 2));

        // Credit backpressure with rsp_rdy low
        for (int i = 0; i < 6; i++) issue(1'b1, 11'h020 + 11'(i), 32'hBEEF_0020 + 32'(i), 4'hF, w);
        bus.rsp_rdy = 1'b0;
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 11'h020 + 11'(i), 32'h0, 4'h0, w);
            wsum += w;
        end
        chk("bp_first4_waits", 32'(wsum), 32'd0);
        bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 11'h024;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_rd_rdy_low", 32'(bus.req_rdy), 32'd0);
            if (i == 2) begin
                bus.req_wr = 1'b1;
                #1;
                chk("bp_wr_rdy", 32'(bus.req_rdy), 32'd1);
                bus.req_wr = 1'b0;
            end
            @(posedge CLK); #1;
        end
        bus.rsp_rdy = 1'b1;
        @(negedge CLK);
        chk("bp_pop_cycle_rdy", 32'(bus.req_rdy), 32'd0);
        @(posedge CLK); #1;
        bus.rsp_rdy = 1'b0;
        @(negedge CLK);
        chk("bp_after_pop_rdy", 32'(bus.req_rdy), 32'd1);
        exp_q.push_back(ref_mem[11'h024]);
        @(posedge CLK); #1;
        bus.req_vld = 1'b0;
        drain();

        // Reset with two responses queued and one read in flight
        bus.rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, 11'h020 + 11'(i), 32'h0, 4'h0, w);
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.rsp_rdy = 1'b1;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        check_sweep("resweep");
        issue(1'b0, 11'h020, 32'h0, 4'h0, w);
        drain();
`else
        @(negedge CLK);
        chk("rst_mid_rsp_vld",   32'(bus.rsp_vld), 32'd0);
        chk("rst_mid_init_done", 32'(init_done),   32'd1);
        chk("rst_mid_cen",       32'(sram_cen),    32'd1);
        repeat (4) @(posedge CLK);
        #1;
`endif
        issue(1'b1, 11'h030, 32'h1234_5678, 4'hF, w);
        issue(1'b0, 11'h030, 32'h0, 4'h0, w);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
